// File: rtl/audio_tone_gen_if.sv
// Sample-side bundle between the tone generator and its consumer (hdmi audio inputs).
// The controller drives the waveform select and attenuation; the generator drives the rest.
interface audio_tone_gen_if #(
  parameter int unsigned AUDIO_BIT_WIDTH = 16
);
  logic [1:0]                        mode;
  logic [3:0]                        volume;
  logic                              clk_audio;
  logic                              sample_strobe;
  logic signed [AUDIO_BIT_WIDTH-1:0] audio_sample_word;

  modport master (
    output mode,
    output volume,
    input  clk_audio,
    input  sample_strobe,
    input  audio_sample_word
  );

  modport slave (
    input  mode,
    input  volume,
    output clk_audio,
    output sample_strobe,
    output audio_sample_word
  );
endinterface

// File: rtl/audio_tone_gen.sv
// DDS audio sample clock plus attenuated square/sawtooth/triangle test tone, all registered
// in the clk_pixel domain.
module audio_tone_gen #(
  parameter int unsigned CLK_RATE        = 74250000,
  parameter int unsigned AUDIO_RATE      = 48000,
  parameter int unsigned TONE_RATE       = 480,
  parameter int unsigned AUDIO_BIT_WIDTH = 16
) (
  input  logic            clk_pixel,
  input  logic            reset,
  audio_tone_gen_if.slave io_audio
);
  localparam int unsigned W  = AUDIO_BIT_WIDTH;
  localparam int unsigned XW = W + 8;
  localparam int unsigned P  = (TONE_RATE == 0) ? 0 : AUDIO_RATE / TONE_RATE;
  localparam int unsigned PS = (P < 2) ? 2 : P;
  localparam int unsigned H  = PS / 2;
  localparam int unsigned IW = $clog2(PS);

  // Rounded phase increment for an AUDIO_RATE carry rate out of a 32-bit accumulator.
  localparam logic [63:0] INC64 =
    ((64'(AUDIO_RATE) << 32) + 64'(CLK_RATE / 2)) / 64'(CLK_RATE);
  localparam logic [31:0] INC = 32'(INC64);

  localparam logic signed [XW-1:0] C_A     = XW'((64'd1 << (W - 1)) - 64'd1);
  localparam logic signed [XW-1:0] C_MIN   = ~C_A;
  localparam logic signed [XW-1:0] C_H     = XW'(H);
  localparam logic signed [XW-1:0] C_STEP  = XW'((64'd1 << W) / 64'(PS));
  localparam logic signed [XW-1:0] C_TSTEP = XW'((64'd1 << W) / 64'(H));

  if ((TONE_RATE == 0) || ((AUDIO_RATE % TONE_RATE) != 0) || ((P % 2) != 0) || (P < 2))
  begin : g_bad_rate
    $error("audio_tone_gen: AUDIO_RATE/TONE_RATE must be an even integer >= 2");
  end

  logic [31:0]          r_acc;
  logic                 r_msb_d;
  logic [IW-1:0]        r_idx;
  logic                 r_strobe;
  logic signed [W-1:0]  r_word;

  logic                 w_rise;
  logic                 w_fall;
  logic signed [XW-1:0] w_idx_x;
  logic signed [W-1:0]  w_wave;
  logic signed [W-1:0]  w_scaled;

  assign w_rise   = r_acc[31] & ~r_msb_d;
  assign w_fall   = ~r_acc[31] & r_msb_d;
  assign w_idx_x  = XW'(r_idx);
  assign w_scaled = w_wave >>> io_audio.volume;

  // Products are formed at XW bits and truncated to the sample width.
  always_comb begin
    w_wave = '0;
    case (io_audio.mode)
      2'd1: w_wave = (r_idx < IW'(H)) ? W'(C_A) : W'(-C_A);
      2'd2: w_wave = W'(C_MIN + w_idx_x * C_STEP);
      2'd3: w_wave = (r_idx < IW'(H)) ? W'(C_MIN + w_idx_x * C_TSTEP)
                                      : W'(C_A - (w_idx_x - C_H) * C_TSTEP);
      default: w_wave = '0;
    endcase
  end

  // The word changes on the falling edge so it is settled for half a period before each rise.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_acc    <= '0;
      r_msb_d  <= 1'b0;
      r_idx    <= '0;
      r_strobe <= 1'b0;
      r_word   <= '0;
    end else begin
      r_acc    <= r_acc + INC;
      r_msb_d  <= r_acc[31];
      r_strobe <= w_rise;
      if (w_fall) begin
        r_word <= w_scaled;
        r_idx  <= (r_idx == IW'(PS - 1)) ? '0 : r_idx + IW'(1);
      end
    end
  end

  assign io_audio.clk_audio         = r_acc[31];
  assign io_audio.sample_strobe     = r_strobe;
  assign io_audio.audio_sample_word = r_word;
endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench: default-rate instance for sample-clock timing and reset behaviour, plus a
// 32-clocks-per-sample instance for fast waveform checks.
module tb_audio_tone_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] vol  = 4'd0;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  logic signed [15:0] samp [0:255];

  always #5 clk = ~clk;

  audio_tone_gen_if #(.AUDIO_BIT_WIDTH(16)) if_def ();
  audio_tone_gen_if #(.AUDIO_BIT_WIDTH(16)) if_fast ();

  assign if_def.mode    = mode;
  assign if_def.volume  = vol;
  assign if_fast.mode   = mode;
  assign if_fast.volume = vol;

  audio_tone_gen u_def (
    .clk_pixel (clk),
    .reset     (rst),
    .io_audio  (if_def.slave)
  );

  // INC = 2^27 exactly: rises at k = 16 + 32n, falls at k = 32n.
  audio_tone_gen #(
    .CLK_RATE        (1536000),
    .AUDIO_RATE      (48000),
    .TONE_RATE       (480),
    .AUDIO_BIT_WIDTH (16)
  ) u_fast (
    .clk_pixel (clk),
    .reset     (rst),
    .io_audio  (if_fast.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic collect_fast(input int n);
    int got;
    int guard;
    logic prev_ca;
    logic pend;
    logic signed [15:0] hold;
    got = 0;
    guard = 0;
    pend = 1'b0;
    prev_ca = if_fast.clk_audio;
    hold = if_fast.audio_sample_word;
    while (got < n && guard < n * 40 + 100) begin
      tick();
      guard++;
      if (pend) begin
        samp[got] = if_fast.audio_sample_word;
        got++;
        pend = 1'b0;
      end
      if (prev_ca && !if_fast.clk_audio) pend = 1'b1;
      if (if_fast.clk_audio && !prev_ca) hold = if_fast.audio_sample_word;
      if (if_fast.clk_audio && prev_ca && (if_fast.audio_sample_word !== hold)) stab_err++;
      prev_ca = if_fast.clk_audio;
    end
    check("collect_count", got, n);
  endtask

  task automatic wait_def_update(input string tag);
    int g;
    logic prev;
    bit seen;
    g = 0;
    seen = 1'b0;
    prev = if_def.clk_audio;
    while (!seen && g < 2000) begin
      tick();
      g++;
      if (prev && !if_def.clk_audio) seen = 1'b1;
      prev = if_def.clk_audio;
    end
    check({tag, "_fall_seen"}, longint'(seen), 1);
    tick();
  endtask

  initial begin
    int rises [0:7];
    int falls [0:7];
    int nr;
    int nf;
    int strobes;
    int strobe_bad;
    int fast_strobes;
    int first_rise;
    int early_strobes;
    int strobe_at;
    int g;
    logic prev;

    // Reset values
    tick();
    tick();
    check("rst_clk_audio", if_def.clk_audio, 0);
    check("rst_strobe", if_def.sample_strobe, 0);
    check("rst_word", longint'(if_def.audio_sample_word), 0);
    check("rst_fast_clk_audio", if_fast.clk_audio, 0);
    rst = 1'b0;

    // Default-rate sample clock timing over 4000 clocks
    nr = 0; nf = 0; strobes = 0; strobe_bad = 0; fast_strobes = 0;
    prev = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      tick();
      if (if_def.clk_audio && !prev && nr < 8) begin rises[nr] = k; nr++; end
      if (!if_def.clk_audio && prev && nf < 8) begin falls[nf] = k; nf++; end
      if (if_def.sample_strobe) begin
        strobes++;
        if (nr == 0 || k != rises[nr-1] + 1) strobe_bad++;
      end
      if (if_fast.sample_strobe) fast_strobes++;
      prev = if_def.clk_audio;
    end
    check("rise_count", nr, 3);
    check("fall_count", nf, 2);
    check("rise0", rises[0], 774);
    check("fall0", falls[0], 1547);
    check("rise1_window", longint'(rises[1] >= 2320 && rises[1] <= 2322), 1);
    check("fall1_window", longint'(falls[1] >= 3092 && falls[1] <= 3094), 1);
    check("rise2_window", longint'(rises[2] >= 3866 && rises[2] <= 3868), 1);
    check("strobe_count", strobes, 3);
    check("strobe_placement", strobe_bad, 0);
    check("fast_strobe_count", fast_strobes, 125);
    check("silence_word", longint'(if_fast.audio_sample_word), 0);

    // Square, full scale
    mode = 2'd1; vol = 4'd0;
    do_reset();
    stab_err = 0;
    collect_fast(200);
    for (int s = 0; s < 200; s++)
      check($sformatf("square_%0d", s), longint'(samp[s]), ((s % 100) < 50) ? 32767 : -32767);
    check("word_stable_high", stab_err, 0);

    // Sawtooth
    mode = 2'd2;
    do_reset();
    collect_fast(101);
    check("saw_0", longint'(samp[0]), -32768);
    check("saw_1", longint'(samp[1]), -32113);
    check("saw_99", longint'(samp[99]), 32077);
    check("saw_100", longint'(samp[100]), -32768);

    // Triangle
    mode = 2'd3;
    do_reset();
    collect_fast(100);
    check("tri_0", longint'(samp[0]), -32768);
    check("tri_49", longint'(samp[49]), 31422);
    check("tri_50", longint'(samp[50]), 32767);
    check("tri_99", longint'(samp[99]), -31423);

    // Square attenuated by 8
    mode = 2'd1; vol = 4'd8;
    do_reset();
    collect_fast(100);
    check("sq_vol8_pos", longint'(samp[0]), 127);
    check("sq_vol8_neg", longint'(samp[50]), -128);

    // Mode switch mid-period and reset during the high phase, default-rate instance
    vol = 4'd0;
    do_reset();
    wait_def_update("upd0");
    check("def_square_word", longint'(if_def.audio_sample_word), 32767);
    mode = 2'd0;
    wait_def_update("upd1");
    check("def_silence_word", longint'(if_def.audio_sample_word), 0);
    mode = 2'd1;
    wait_def_update("upd2");
    check("def_square_again", longint'(if_def.audio_sample_word), 32767);
    g = 0;
    while (!if_def.clk_audio && g < 2000) begin tick(); g++; end
    check("def_high_seen", if_def.clk_audio, 1);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_clk_audio", if_def.clk_audio, 0);
    check("midrst_strobe", if_def.sample_strobe, 0);
    check("midrst_word", longint'(if_def.audio_sample_word), 0);
    check("midrst_fast_word", longint'(if_fast.audio_sample_word), 0);
    first_rise = -1; early_strobes = 0; strobe_at = -1;
    for (int k = 1; k <= 900; k++) begin
      tick();
      if (if_def.clk_audio && first_rise < 0) first_rise = k;
      if (if_def.sample_strobe) begin
        if (k < 775) early_strobes++;
        if (strobe_at < 0) strobe_at = k;
      end
    end
    check("post_rst_rise", first_rise, 774);
    check("post_rst_strobe", strobe_at, 775);
    check("no_partial_pulse", early_strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
